// File: rtl/mem_issue_queue_pkg.sv
// mem_issue_queue_pkg: shared constants for the memory issue queue.
//   UOP_LOAD / UOP_STORE : opcodes that select the operand-ready rule
//   FUNC_B / FUNC_H / FUNC_W : access size codes carried in the func field
//   bundle_width()       : issued bundle width, payload fields plus the val bit
// Bundle layout, MSB to LSB: {val, func[9:0], brmask, uop[6:0], pc, imm, rd, op2, op1}
package mem_issue_queue_pkg;
  localparam logic [6:0] UOP_LOAD  = 7'b0000011;
  localparam logic [6:0] UOP_STORE = 7'b0100011;
  localparam logic [9:0] FUNC_B    = 10'd0;
  localparam logic [9:0] FUNC_H    = 10'd1;
  localparam logic [9:0] FUNC_W    = 10'd2;

  // Payload is 4*32+rd+brmask+uop+func; the val bit sits above it at WIDTH-1.
  function automatic int bundle_width(input int wreg, input int wbrm);
    return 4*32 + wreg + wbrm + 7 + 10 + 1;
  endfunction
endpackage

// File: rtl/mem_issue_queue_if.sv
// mem_issue_queue_if: dispatch, writeback broadcast, kill and issue signals.
//   master : dispatch/writeback side (drives i_*, observes o_*)
//   slave  : the queue
interface mem_issue_queue_if #(
  parameter int WIDTH_Q   = 3,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_BRM = 4
);
  localparam int WIDTH = mem_issue_queue_pkg::bundle_width(WIDTH_REG, WIDTH_BRM);

  logic                 i_enq_valid;
  logic                 o_enq_ready;
  logic [6:0]           i_enq_uop;
  logic [9:0]           i_enq_func;
  logic [WIDTH_BRM-1:0] i_enq_brmask;
  logic [31:0]          i_enq_pc;
  logic [31:0]          i_enq_imm;
  logic [WIDTH_REG-1:0] i_enq_rd;
  logic [WIDTH_REG-1:0] i_enq_rs1;
  logic [WIDTH_REG-1:0] i_enq_rs2;
  logic                 i_enq_rdy1;
  logic                 i_enq_rdy2;
  logic [31:0]          i_enq_op1;
  logic [31:0]          i_enq_op2;
  logic                 i_wb_valid;
  logic [WIDTH_REG-1:0] i_wb_addr;
  logic [31:0]          i_wb_data;
  logic [WIDTH_BRM-1:0] i_kill_mask;
  logic [WIDTH-1:0]     o_instr;
  logic [WIDTH_Q:0]     o_count;

  modport master (
    output i_enq_valid, i_enq_uop, i_enq_func, i_enq_brmask, i_enq_pc, i_enq_imm, i_enq_rd,
           i_enq_rs1, i_enq_rs2, i_enq_rdy1, i_enq_rdy2, i_enq_op1, i_enq_op2,
           i_wb_valid, i_wb_addr, i_wb_data, i_kill_mask,
    input  o_enq_ready, o_instr, o_count
  );
  modport slave (
    input  i_enq_valid, i_enq_uop, i_enq_func, i_enq_brmask, i_enq_pc, i_enq_imm, i_enq_rd,
           i_enq_rs1, i_enq_rs2, i_enq_rdy1, i_enq_rdy2, i_enq_op1, i_enq_op2,
           i_wb_valid, i_wb_addr, i_wb_data, i_kill_mask,
    output o_enq_ready, o_instr, o_count
  );
endinterface

// File: rtl/mem_issue_queue_entry.sv
// mem_issue_queue_entry: one queue slot.
//   wr/clr        : load from the enq_* fields / free the slot (pop)
//   wb_*          : writeback broadcast, compared against both source tags
//   kill_mask     : branch kill; killed reports a hit this cycle, slot drops next edge
//   rdy*_v, op*_v : operand view used for issue; with BYPASS set it includes
//                   this cycle's wakeup and muxes wb_data in for a not-yet-latched operand
module mem_issue_queue_entry #(
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_BRM = 4,
  parameter bit BYPASS    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 clr,
  input  logic [6:0]           enq_uop,
  input  logic [9:0]           enq_func,
  input  logic [WIDTH_BRM-1:0] enq_brmask,
  input  logic [31:0]          enq_pc,
  input  logic [31:0]          enq_imm,
  input  logic [WIDTH_REG-1:0] enq_rd,
  input  logic [WIDTH_REG-1:0] enq_rs1,
  input  logic [WIDTH_REG-1:0] enq_rs2,
  input  logic                 enq_rdy1,
  input  logic                 enq_rdy2,
  input  logic [31:0]          enq_op1,
  input  logic [31:0]          enq_op2,
  input  logic                 wb_valid,
  input  logic [WIDTH_REG-1:0] wb_addr,
  input  logic [31:0]          wb_data,
  input  logic [WIDTH_BRM-1:0] kill_mask,
  output logic                 valid,
  output logic                 killed,
  output logic [6:0]           uop,
  output logic [9:0]           func,
  output logic [WIDTH_BRM-1:0] brmask,
  output logic [31:0]          pc,
  output logic [31:0]          imm,
  output logic [WIDTH_REG-1:0] rd,
  output logic                 rdy1_v,
  output logic                 rdy2_v,
  output logic [31:0]          op1_v,
  output logic [31:0]          op2_v
);
  logic [WIDTH_REG-1:0] rs1, rs2;
  logic                 rdy1, rdy2;
  logic [31:0]          op1, op2;
  logic                 wake1, wake2, take1, take2;

  assign wake1  = valid && !rdy1 && wb_valid && wb_addr == rs1;
  assign wake2  = valid && !rdy2 && wb_valid && wb_addr == rs2;
  // Broadcast landing in the same cycle as the enqueue; tag 0 is never waited on.
  assign take1  = !enq_rdy1 && enq_rs1 != '0 && wb_valid && wb_addr == enq_rs1;
  assign take2  = !enq_rdy2 && enq_rs2 != '0 && wb_valid && wb_addr == enq_rs2;
  assign killed = valid && |(brmask & kill_mask);

  assign rdy1_v = rdy1 || (BYPASS && wake1);
  assign rdy2_v = rdy2 || (BYPASS && wake2);
  assign op1_v  = rdy1 ? op1 : wb_data;
  assign op2_v  = rdy2 ? op2 : wb_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rdy1  <= 1'b0;
      rdy2  <= 1'b0;
    end else if (wr) begin
      valid  <= 1'b1;
      uop    <= enq_uop;
      func   <= enq_func;
      brmask <= enq_brmask;
      pc     <= enq_pc;
      imm    <= enq_imm;
      rd     <= enq_rd;
      rs1    <= enq_rs1;
      rs2    <= enq_rs2;
      rdy1   <= enq_rdy1 || enq_rs1 == '0 || take1;
      rdy2   <= enq_rdy2 || enq_rs2 == '0 || take2;
      op1    <= take1 ? wb_data : enq_op1;
      op2    <= take2 ? wb_data : enq_op2;
    end else begin
      if (clr || killed) valid <= 1'b0;
      if (wake1) begin
        rdy1 <= 1'b1;
        op1  <= wb_data;
      end
      if (wake2) begin
        rdy2 <= 1'b1;
        op2  <= wb_data;
      end
    end
  end
endmodule

// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order issue queue for load/store uops.
//   i_clk, i_rst : clock, synchronous active-high reset
//   q (slave)    : enqueue, writeback broadcast, kill mask, issued bundle, occupancy
// Only the head may issue, one op per cycle, into a registered bundle.
// Killed or invalid head slots are popped without issuing.
// Build option MEM_ISSUE_WB_BYPASS_EN: the head also sees this cycle's writeback,
// so an op whose last operand arrives on the broadcast issues that same cycle.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int WIDTH_Q   = 3,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_BRM = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  mem_issue_queue_if.slave q
);
  localparam int DEPTH = 1 << WIDTH_Q;
  localparam int WIDTH = bundle_width(WIDTH_REG, WIDTH_BRM);
`ifdef MEM_ISSUE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WIDTH_Q-1:0]                  head, tail;
  logic [WIDTH_Q:0]                    count;
  logic [WIDTH-1:0]                    instr;
  logic [DEPTH-1:0]                    wr, clr, e_valid, e_killed, e_rdy1, e_rdy2;
  logic [DEPTH-1:0][6:0]               e_uop;
  logic [DEPTH-1:0][9:0]               e_func;
  logic [DEPTH-1:0][WIDTH_BRM-1:0]     e_brmask;
  logic [DEPTH-1:0][31:0]              e_pc, e_imm, e_op1, e_op2;
  logic [DEPTH-1:0][WIDTH_REG-1:0]     e_rd;
  logic                                enq_ready, push, pop, issue, h_ready;

  // Registered count only: a full queue refuses even in a cycle that issues.
  assign enq_ready = count != (WIDTH_Q+1)'(DEPTH);
  // A killed offer is acknowledged but never takes a slot.
  assign push      = q.i_enq_valid && enq_ready && !(|(q.i_enq_brmask & q.i_kill_mask));
  assign h_ready   = e_rdy1[head] && (e_uop[head] != UOP_STORE || e_rdy2[head]);
  assign issue     = count != '0 && e_valid[head] && !e_killed[head] && h_ready;
  assign pop       = count != '0 && (issue || !e_valid[head]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign wr[i]  = push && tail == WIDTH_Q'(i);
    assign clr[i] = pop && head == WIDTH_Q'(i);
    mem_issue_queue_entry #(
      .WIDTH_REG(WIDTH_REG), .WIDTH_BRM(WIDTH_BRM), .BYPASS(BYPASS)
    ) u_ent (
      .clk(i_clk), .rst(i_rst), .wr(wr[i]), .clr(clr[i]),
      .enq_uop(q.i_enq_uop), .enq_func(q.i_enq_func), .enq_brmask(q.i_enq_brmask),
      .enq_pc(q.i_enq_pc), .enq_imm(q.i_enq_imm), .enq_rd(q.i_enq_rd),
      .enq_rs1(q.i_enq_rs1), .enq_rs2(q.i_enq_rs2),
      .enq_rdy1(q.i_enq_rdy1), .enq_rdy2(q.i_enq_rdy2),
      .enq_op1(q.i_enq_op1), .enq_op2(q.i_enq_op2),
      .wb_valid(q.i_wb_valid), .wb_addr(q.i_wb_addr), .wb_data(q.i_wb_data),
      .kill_mask(q.i_kill_mask),
      .valid(e_valid[i]), .killed(e_killed[i]), .uop(e_uop[i]), .func(e_func[i]),
      .brmask(e_brmask[i]), .pc(e_pc[i]), .imm(e_imm[i]), .rd(e_rd[i]),
      .rdy1_v(e_rdy1[i]), .rdy2_v(e_rdy2[i]), .op1_v(e_op1[i]), .op2_v(e_op2[i])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      instr <= '0;
    end else begin
      if (push) tail <= tail + WIDTH_Q'(1);
      if (pop)  head <= head + WIDTH_Q'(1);
      count <= count + (WIDTH_Q+1)'(push) - (WIDTH_Q+1)'(pop);
      instr <= issue ? {1'b1, e_func[head], e_brmask[head], e_uop[head], e_pc[head],
                        e_imm[head], e_rd[head], e_op2[head], e_op1[head]} : '0;
    end
  end

  assign q.o_enq_ready = enq_ready;
  assign q.o_count     = count;
  assign q.o_instr     = instr;
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue: directed vector table plus hand sequences for the
// multi-cycle cases (delayed wakeup, full queue, kill, reset mid-operation).
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;
  localparam int WQ = 3, WR = 5, WB = 4;
  localparam int W  = 155;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  mem_issue_queue_if #(.WIDTH_Q(WQ), .WIDTH_REG(WR), .WIDTH_BRM(WB)) qif ();
  mem_issue_queue #(.WIDTH_Q(WQ), .WIDTH_REG(WR), .WIDTH_BRM(WB)) dut (
    .i_clk(clk), .i_rst(rst), .q(qif)
  );

  // Bundle decode for the default widths.
  logic [W-1:0] ins;
  logic         o_val;
  logic [31:0]  o_op1, o_op2, o_imm, o_pc;
  logic [4:0]   o_rd;
  logic [6:0]   o_uop;
  logic [9:0]   o_func;
  assign ins    = qif.o_instr;
  assign o_op1  = ins[31:0];
  assign o_op2  = ins[63:32];
  assign o_rd   = ins[68:64];
  assign o_imm  = ins[100:69];
  assign o_pc   = ins[132:101];
  assign o_uop  = ins[139:133];
  assign o_func = ins[153:144];
  assign o_val  = ins[154];

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    qif.i_enq_valid = 1'b0;
    qif.i_wb_valid  = 1'b0;
    qif.i_kill_mask = '0;
  endtask

  // rd is derived from imm so each issued op carries a distinct, predictable tag.
  task automatic enq(input int uop, input int brm, input int rs1, input int rdy1, input int op1,
                     input int rs2, input int rdy2, input int op2, input int imm);
    qif.i_enq_valid  = 1'b1;
    qif.i_enq_uop    = 7'(uop);
    qif.i_enq_func   = FUNC_W;
    qif.i_enq_brmask = 4'(brm);
    qif.i_enq_pc     = 32'h1000;
    qif.i_enq_imm    = 32'(imm);
    qif.i_enq_rd     = 5'(imm) ^ 5'd7;
    qif.i_enq_rs1    = 5'(rs1);
    qif.i_enq_rs2    = 5'(rs2);
    qif.i_enq_rdy1   = rdy1[0];
    qif.i_enq_rdy2   = rdy2[0];
    qif.i_enq_op1    = 32'(op1);
    qif.i_enq_op2    = 32'(op2);
  endtask

  task automatic wb(input int a, input int d);
    qif.i_wb_valid = 1'b1;
    qif.i_wb_addr  = 5'(a);
    qif.i_wb_data  = 32'(d);
  endtask

  typedef struct {
    int enq, uop, brm, rs1, rdy1, op1, rs2, rdy2, op2, imm;
    int wbv, wba, wbd, kill;
    int ev, euop, eop1, eop2, eimm, ecnt;
  } vec_t;

  function automatic vec_t mk(input int enq, uop, brm, rs1, rdy1, op1, rs2, rdy2, op2, imm,
                              input int wbv, wba, wbd, kill,
                              input int ev, euop, eop1, eop2, eimm, ecnt);
    vec_t v;
    v.enq = enq; v.uop = uop; v.brm = brm; v.rs1 = rs1; v.rdy1 = rdy1; v.op1 = op1;
    v.rs2 = rs2; v.rdy2 = rdy2; v.op2 = op2; v.imm = imm;
    v.wbv = wbv; v.wba = wba; v.wbd = wbd; v.kill = kill;
    v.ev = ev; v.euop = euop; v.eop1 = eop1; v.eop2 = eop2; v.eimm = eimm; v.ecnt = ecnt;
    return v;
  endfunction

  localparam int NV = 18;
  vec_t vecs[NV];
  int L, S, got;

  initial begin
    L = int'(UOP_LOAD);
    S = int'(UOP_STORE);
    //            enq uop brm rs1 r1 op1    rs2 r2 op2   imm  wb wa wd    kil ev euop op1  op2   imm cnt
    vecs[0]  = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  0, 0,   0,    0,    0, 0);
    vecs[1]  = mk(1,  L,  0,  1,  1, 'h10,  0,  0, 0,     4,  0, 0, 0,     0,  0, 0,   0,    0,    0, 1);
    vecs[2]  = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  1, L,   'h10, 0,    4, 0);
    vecs[3]  = mk(1,  L,  0,  9,  0, 0,     0,  0, 0,     8,  1, 9, 'h55,  0,  0, 0,   0,    0,    0, 1);
    vecs[4]  = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  1, L,   'h55, 0,    8, 0);
    vecs[5]  = mk(1,  L,  0,  0,  0, 'h77,  0,  0, 0,    12,  0, 0, 0,     0,  0, 0,   0,    0,    0, 1);
    vecs[6]  = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  1, L,   'h77, 0,   12, 0);
    vecs[7]  = mk(1,  S,  0,  1,  1, 'hA0,  2,  1, 'hB0, 16,  0, 0, 0,     0,  0, 0,   0,    0,    0, 1);
    vecs[8]  = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  1, S,   'hA0, 'hB0,16, 0);
    vecs[9]  = mk(1,  L,  4,  1,  1, 'h33,  0,  0, 0,    20,  0, 0, 0,     4,  0, 0,   0,    0,    0, 0);
    vecs[10] = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  0, 0,   0,    0,    0, 0);
    vecs[11] = mk(1,  L,  0,  1,  1, 1,     0,  0, 0,    24,  0, 0, 0,     0,  0, 0,   0,    0,    0, 1);
    vecs[12] = mk(1,  L,  0,  1,  1, 2,     0,  0, 0,    28,  0, 0, 0,     0,  1, L,   1,    0,   24, 1);
    vecs[13] = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  1, L,   2,    0,   28, 0);
    vecs[14] = mk(1,  L,  1,  3,  0, 0,     0,  0, 0,    32,  1, 4, 'h99,  0,  0, 0,   0,    0,    0, 1);
    vecs[15] = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  0, 0,   0,    0,    0, 1);
    vecs[16] = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     1,  0, 0,   0,    0,    0, 1);
    vecs[17] = mk(0,  0,  0,  0,  0, 0,     0,  0, 0,     0,  0, 0, 0,     0,  0, 0,   0,    0,    0, 0);

    enq(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0);
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("reset.val",   64'(o_val), 0);
    chk("reset.instr", 64'(|ins), 0);
    chk("reset.count", 64'(qif.o_count), 0);
    chk("reset.ready", 64'(qif.o_enq_ready), 1);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      idle();
      if (vecs[i].enq != 0)
        enq(vecs[i].uop, vecs[i].brm, vecs[i].rs1, vecs[i].rdy1, vecs[i].op1,
            vecs[i].rs2, vecs[i].rdy2, vecs[i].op2, vecs[i].imm);
      if (vecs[i].wbv != 0) wb(vecs[i].wba, vecs[i].wbd);
      qif.i_kill_mask = 4'(vecs[i].kill);
      tick();
      chk($sformatf("v%0d.val", i),   64'(o_val), 64'(vecs[i].ev));
      chk($sformatf("v%0d.count", i), 64'(qif.o_count), 64'(vecs[i].ecnt));
      chk($sformatf("v%0d.ready", i), 64'(qif.o_enq_ready), 64'(vecs[i].ecnt != 8));
      if (vecs[i].ev != 0) begin
        chk($sformatf("v%0d.uop", i),  64'(o_uop), 64'(vecs[i].euop));
        chk($sformatf("v%0d.op1", i),  64'(o_op1), 64'(vecs[i].eop1));
        chk($sformatf("v%0d.op2", i),  64'(o_op2), 64'(vecs[i].eop2));
        chk($sformatf("v%0d.imm", i),  64'(o_imm), 64'(vecs[i].eimm));
        chk($sformatf("v%0d.rd", i),   64'(o_rd),  64'(5'(vecs[i].eimm) ^ 5'd7));
        chk($sformatf("v%0d.pc", i),   64'(o_pc),  64'h1000);
        chk($sformatf("v%0d.func", i), 64'(o_func), 64'(FUNC_W));
      end else begin
        chk($sformatf("v%0d.zero", i), 64'(|ins), 0);
      end
    end

    // Store waiting on op2; wakeup arrives a few cycles later.
    idle();
    enq(S, 0, 1, 1, 'h200, 7, 0, 0, 40);
    tick();
    idle();
    chk("st.count", 64'(qif.o_count), 1);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("st.wait%0d", c), 64'(o_val), 0);
    end
    wb(7, 'hDEAD);
    tick();
    idle();
`ifdef MEM_ISSUE_WB_BYPASS_EN
    chk("st.bypass.val", 64'(o_val), 1);
`else
    chk("st.latch.val", 64'(o_val), 0);
    tick();
    chk("st.latch.val2", 64'(o_val), 1);
`endif
    chk("st.op2", 64'(o_op2), 64'hDEAD);
    chk("st.op1", 64'(o_op1), 64'h200);
    chk("st.uop", 64'(o_uop), 64'(UOP_STORE));
    tick();
    chk("st.after", 64'(o_val), 0);
    chk("st.count0", 64'(qif.o_count), 0);

    // Fill all 8 slots waiting on tag 5, then release them with one broadcast.
    for (int i = 0; i < 8; i++) begin
      enq(L, 0, 5, 0, 0, 0, 0, 0, 100 + i);
      tick();
    end
    idle();
    chk("full.count", 64'(qif.o_count), 8);
    chk("full.ready", 64'(qif.o_enq_ready), 0);
    enq(L, 0, 1, 1, 1, 0, 0, 0, 999);
    tick();
    chk("full.refuse", 64'(qif.o_count), 8);
    wb(5, 'h5A5A);
    tick();
    idle();
`ifdef MEM_ISSUE_WB_BYPASS_EN
    chk("full.wbcount", 64'(qif.o_count), 7);
`else
    chk("full.wbcount", 64'(qif.o_count), 8);
`endif
    got = 0;
    for (int c = 0; c < 14; c++) begin
      if (o_val) begin
        chk($sformatf("full.imm%0d", got), 64'(o_imm), 64'(100 + got));
        chk($sformatf("full.op1_%0d", got), 64'(o_op1), 64'h5A5A);
        got++;
      end
      tick();
    end
    chk("full.issued", 64'(got), 8);
    chk("full.drained", 64'(qif.o_count), 0);

    // Kill the older of two waiting ops, then wake both: only the survivor issues.
    enq(L, 2, 6, 0, 0, 0, 0, 0, 'hA);
    tick();
    enq(L, 1, 6, 0, 0, 0, 0, 0, 'hB);
    tick();
    idle();
    chk("kill.count", 64'(qif.o_count), 2);
    qif.i_kill_mask = 4'b0010;
    tick();
    idle();
    chk("kill.noissue", 64'(o_val), 0);
    wb(6, 'h66);
    tick();
    idle();
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_val) begin
        chk("kill.imm", 64'(o_imm), 64'hB);
        chk("kill.op1", 64'(o_op1), 64'h66);
        got++;
      end
      tick();
    end
    chk("kill.issued", 64'(got), 1);
    chk("kill.count0", 64'(qif.o_count), 0);

    // Reset with four ops queued; a broadcast during and after reset must not issue.
    for (int i = 0; i < 4; i++) begin
      enq(L, 0, 8, 0, 0, 0, 0, 0, 200 + i);
      tick();
    end
    idle();
    chk("rst.count4", 64'(qif.o_count), 4);
    rst = 1'b1;
    wb(8, 'h88);
    tick();
    rst = 1'b0;
    chk("rst.count", 64'(qif.o_count), 0);
    chk("rst.val", 64'(o_val), 0);
    chk("rst.ready", 64'(qif.o_enq_ready), 1);
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst.quiet%0d", c), 64'(o_val), 0);
      tick();
    end
    chk("rst.count_end", 64'(qif.o_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
